// File: rtl/line_draw_scheduler_if.sv
// Bundle of requester, drawer and status signals around line_draw_scheduler.
// master: requester/drawer side; slave: the scheduler itself.
interface line_draw_scheduler_if #(
    parameter int unsigned N = 11,
    parameter int unsigned R = 4
);
    localparam int unsigned GW = $clog2(R);

    logic [R-1:0]   req;
    logic [R*N-1:0] req_x0;
    logic [R*N-1:0] req_y0;
    logic [R*N-1:0] req_x1;
    logic [R*N-1:0] req_y1;
    logic           done;
    logic           start;
    logic [N-1:0]   x0;
    logic [N-1:0]   y0;
    logic [N-1:0]   x1;
    logic [N-1:0]   y1;
    logic [R-1:0]   ack;
    logic [GW-1:0]  grant_id;
    logic           busy;
    logic           timeout_err;

    modport master (
        output req, req_x0, req_y0, req_x1, req_y1, done,
        input  start, x0, y0, x1, y1, ack, grant_id, busy, timeout_err
    );

    modport slave (
        input  req, req_x0, req_y0, req_x1, req_y1, done,
        output start, x0, y0, x1, y1, ack, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/line_draw_scheduler.sv
// Round-robin scheduler sharing one line drawer among R segment requesters.
// Optional WAIT watchdog enabled by defining LINE_SCHED_TIMEOUT_EN.
module line_draw_scheduler #(
    parameter int unsigned N       = 11,
    parameter int unsigned R       = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic                  clock,
    input logic                  reset,
    line_draw_scheduler_if.slave bus
);
    localparam int unsigned GW = $clog2(R);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state;
    logic [GW-1:0] last;
    logic [GW-1:0] cand;
    logic [GW-1:0] pick;
    logic          found;
    logic [N-1:0]  sel_x0;
    logic [N-1:0]  sel_y0;
    logic [N-1:0]  sel_x1;
    logic [N-1:0]  sel_y1;
    logic [R-1:0]  grant_onehot;
    logic          start;
    logic [R-1:0]  ack;
    logic          busy;
    logic [N-1:0]  x0;
    logic [N-1:0]  y0;
    logic [N-1:0]  x1;
    logic [N-1:0]  y1;
    logic [GW-1:0] grant_id;
    logic          timeout_flag;

`ifdef LINE_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT);
    logic [CW-1:0] wait_count;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    // Rotating-priority pick: first pending requester after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= R; k++) begin
            cand = GW'((32'(last) + k) % R);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Endpoint mux for the picked requester.
    always_comb begin
        sel_x0 = '0;
        sel_y0 = '0;
        sel_x1 = '0;
        sel_y1 = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (pick == GW'(i)) begin
                sel_x0 = bus.req_x0[i*N +: N];
                sel_y0 = bus.req_y0[i*N +: N];
                sel_x1 = bus.req_x1[i*N +: N];
                sel_y1 = bus.req_y1[i*N +: N];
            end
        end
    end

    // One-hot form of the current grant, used for the ack pulse.
    always_comb begin
        grant_onehot           = '0;
        grant_onehot[grant_id] = 1'b1;
    end

    // Scheduler FSM; start/ack/busy are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last         <= GW'(R - 1);
            start        <= 1'b0;
            ack          <= '0;
            busy         <= 1'b0;
            x0           <= '0;
            y0           <= '0;
            x1           <= '0;
            y1           <= '0;
            grant_id     <= '0;
            timeout_flag <= 1'b0;
`ifdef LINE_SCHED_TIMEOUT_EN
            wait_count   <= '0;
`endif
        end else begin
            start <= 1'b0;
            ack   <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        x0       <= sel_x0;
                        y0       <= sel_y0;
                        x1       <= sel_x1;
                        y1       <= sel_y1;
                        grant_id <= pick;
                        start    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef LINE_SCHED_TIMEOUT_EN
                    wait_count <= '0;
`endif
                end
                WAIT: begin
                    if (bus.done) begin
                        ack   <= grant_onehot;
                        state <= ACK;
                    end
`ifdef LINE_SCHED_TIMEOUT_EN
                    else if (wait_count == CW'(TIMEOUT - 1)) begin
                        ack          <= grant_onehot;
                        timeout_flag <= 1'b1;
                        state        <= ACK;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
`endif
                end
                ACK: begin
                    last  <= grant_id;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start       = start;
    assign bus.ack         = ack;
    assign bus.busy        = busy;
    assign bus.x0          = x0;
    assign bus.y0          = y0;
    assign bus.x1          = x1;
    assign bus.y1          = y1;
    assign bus.grant_id    = grant_id;
    assign bus.timeout_err = timeout_flag;
endmodule

// File: tb/tb_line_draw_scheduler.sv
// Self-checking bench for line_draw_scheduler: vector table, corner sequences,
// and randomized traffic against a round-robin transaction model.
module tb_line_draw_scheduler;
    localparam int unsigned N       = 11;
    localparam int unsigned R       = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    line_draw_scheduler_if #(.N(N), .R(R)) bus();

    line_draw_scheduler #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int ack_tally[R];

    logic [N-1:0] cx0[R];
    logic [N-1:0] cy0[R];
    logic [N-1:0] cx1[R];
    logic [N-1:0] cy1[R];

    typedef struct {
        logic [R-1:0] req;
        int unsigned  done_after;
        int unsigned  exp_grant;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_coords();
        for (int unsigned i = 0; i < R; i++) begin
            bus.req_x0[i*N +: N] = cx0[i];
            bus.req_y0[i*N +: N] = cy0[i];
            bus.req_x1[i*N +: N] = cx1[i];
            bus.req_y1[i*N +: N] = cy1[i];
        end
    endtask

    // Round-robin rule: first pending index after last, wrapping; R means none.
    function automatic int unsigned rr_winner(input logic [R-1:0] pend, input int unsigned last);
        for (int unsigned k = 1; k <= R; k++) begin
            if (pend[(last + k) % R]) return (last + k) % R;
        end
        return R;
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        tick();
        tick();
        check("rst start", 64'(bus.start), 64'd0);
        check("rst ack", 64'(bus.ack), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst x0", 64'(bus.x0), 64'd0);
        check("rst y0", 64'(bus.y0), 64'd0);
        check("rst x1", 64'(bus.x1), 64'd0);
        check("rst y1", 64'(bus.y1), 64'd0);
        check("rst grant_id", 64'(bus.grant_id), 64'd0);
        check("rst timeout_err", 64'(bus.timeout_err), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < int'(R); i++) ack_tally[i] = 0;
    endtask

    // One full segment starting from an IDLE cycle; ends in the following IDLE cycle.
    task automatic run_segment(input string tag, input logic [R-1:0] req,
                               input int unsigned done_after, input bit spurious,
                               input bit keep, input int unsigned exp);
        logic [R-1:0] onehot;
        onehot      = '0;
        onehot[exp] = 1'b1;
        bus.req = req;
        drive_coords();
        tick();
        check({tag, " start"}, 64'(bus.start), 64'd1);
        check({tag, " busy issue"}, 64'(bus.busy), 64'd1);
        check({tag, " grant_id"}, 64'(bus.grant_id), 64'(exp));
        check({tag, " x0"}, 64'(bus.x0), 64'(cx0[exp]));
        check({tag, " y0"}, 64'(bus.y0), 64'(cy0[exp]));
        check({tag, " x1"}, 64'(bus.x1), 64'(cx1[exp]));
        check({tag, " y1"}, 64'(bus.y1), 64'(cy1[exp]));
        check({tag, " ack issue"}, 64'(bus.ack), 64'd0);
        if (spurious) bus.done = 1'b1;
        for (int unsigned j = 1; j <= done_after; j++) begin
            tick();
            bus.done = 1'b0;
            check({tag, " start wait"}, 64'(bus.start), 64'd0);
            check({tag, " ack wait"}, 64'(bus.ack), 64'd0);
            if (j == done_after) bus.done = 1'b1;
        end
        tick();
        bus.done = 1'b0;
        check({tag, " ack"}, 64'(bus.ack), 64'(onehot));
        check({tag, " busy ack"}, 64'(bus.busy), 64'd1);
        if (!keep) bus.req[exp] = 1'b0;
        tick();
        check({tag, " busy idle"}, 64'(bus.busy), 64'd0);
        check({tag, " ack idle"}, 64'(bus.ack), 64'd0);
        check({tag, " grant hold"}, 64'(bus.grant_id), 64'(exp));
        check({tag, " x1 hold"}, 64'(bus.x1), 64'(cx1[exp]));
    endtask

    // Every ack pulse must be one-hot; tally acks per requester.
    always @(negedge clock) begin
        if (!reset && bus.ack != '0) begin
            check("ack onehot", 64'($countones(bus.ack)), 64'd1);
            for (int i = 0; i < int'(R); i++) if (bus.ack[i]) ack_tally[i]++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [R-1:0] pend;
        int unsigned  mlast;
        int unsigned  w;
        bit           keep;

        bus.req    = '0;
        bus.done   = 1'b0;
        bus.req_x0 = '0;
        bus.req_y0 = '0;
        bus.req_x1 = '0;
        bus.req_y1 = '0;
        for (int unsigned i = 0; i < R; i++) begin
            cx0[i] = N'(100 * i + 3);
            cy0[i] = N'(100 * i + 7);
            cx1[i] = N'(2047 - i);
            cy1[i] = N'(1024 + i);
        end
        cx0[1] = 11'd10;
        cy0[1] = 11'd20;
        cx1[1] = 11'd300;
        cy1[1] = 11'd40;

        tbl[0] = '{4'b0010, 5, 1};
        tbl[1] = '{4'b1111, 1, 2};
        tbl[2] = '{4'b1011, 2, 3};
        tbl[3] = '{4'b0110, 3, 1};
        tbl[4] = '{4'b0001, 1, 0};
        tbl[5] = '{4'b1001, 4, 3};
        tbl[6] = '{4'b0111, 2, 0};
        tbl[7] = '{4'b1000, 1, 3};

        // Vector table from reset (requester 0 has top priority first).
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_segment($sformatf("tbl%0d", i), tbl[i].req, tbl[i].done_after, 1'b0, 1'b0, tbl[i].exp_grant);
        end
        bus.req = '0;

        // Fairness: all requesters held high for 8 segments.
        do_reset();
        for (int unsigned s = 0; s < 8; s++) begin
            run_segment($sformatf("fair%0d", s), 4'b1111, 1, 1'b0, 1'b1, s % R);
        end
        bus.req = '0;
        for (int i = 0; i < int'(R); i++) check($sformatf("fair tally%0d", i), 64'(ack_tally[i]), 64'd2);

        // Spurious done in IDLE and ISSUE is discarded.
        do_reset();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("spur ack idle", 64'(bus.ack), 64'd0);
        check("spur busy idle", 64'(bus.busy), 64'd0);
        tick();
        check("spur ack idle2", 64'(bus.ack), 64'd0);
        run_segment("spur", 4'b0100, 3, 1'b1, 1'b0, 2);

        // Back-to-back: requester 3 re-raises right after its ack, 0 also pending.
        do_reset();
        run_segment("b2b a", 4'b1000, 1, 1'b0, 1'b0, 3);
        run_segment("b2b b", 4'b1001, 2, 1'b0, 1'b0, 0);
        run_segment("b2b c", 4'b1000, 1, 1'b0, 1'b0, 3);

        // Reset during WAIT aborts the segment.
        do_reset();
        bus.req = 4'b0100;
        drive_coords();
        tick();
        check("abort grant", 64'(bus.grant_id), 64'd2);
        tick();
        tick();
        check("abort busy wait", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        check("abort start", 64'(bus.start), 64'd0);
        check("abort ack", 64'(bus.ack), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort grant rst", 64'(bus.grant_id), 64'd0);
        reset = 1'b0;
        run_segment("abort rereq", 4'b0101, 2, 1'b0, 1'b0, 0);
        run_segment("abort next", 4'b0100, 1, 1'b0, 1'b0, 2);

        // Watchdog: done never arrives.
        do_reset();
        bus.req = 4'b0001;
        tick();
        check("wd start", 64'(bus.start), 64'd1);
        tick();
`ifdef LINE_SCHED_TIMEOUT_EN
        for (int unsigned j = 1; j < 16; j++) begin
            tick();
            check($sformatf("wd ack early%0d", j), 64'(bus.ack), 64'd0);
            check("wd err early", 64'(bus.timeout_err), 64'd0);
        end
        tick();
        check("wd ack", 64'(bus.ack), 64'd1);
        check("wd err", 64'(bus.timeout_err), 64'd1);
        bus.req = '0;
        tick();
        check("wd busy idle", 64'(bus.busy), 64'd0);
        check("wd err hold", 64'(bus.timeout_err), 64'd1);
        run_segment("wd after", 4'b0010, 2, 1'b0, 1'b0, 1);
        check("wd err sticky", 64'(bus.timeout_err), 64'd1);
        do_reset();
`else
        for (int unsigned j = 1; j <= 20; j++) begin
            tick();
            check($sformatf("nowd ack%0d", j), 64'(bus.ack), 64'd0);
            check("nowd err", 64'(bus.timeout_err), 64'd0);
            check("nowd busy", 64'(bus.busy), 64'd1);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("nowd ack final", 64'(bus.ack), 64'd1);
        bus.req = '0;
        tick();
        check("nowd busy idle", 64'(bus.busy), 64'd0);
`endif

        // Randomized traffic checked against the round-robin transaction model.
        do_reset();
        pend  = '0;
        mlast = R - 1;
        for (int s = 0; s < 40; s++) begin
            for (int unsigned i = 0; i < R; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    cx0[i]  = N'($urandom);
                    cy0[i]  = N'($urandom);
                    cx1[i]  = N'($urandom);
                    cy1[i]  = N'($urandom);
                end
            end
            if (pend == '0) begin
                bus.req = '0;
                tick();
                check("rand idle busy", 64'(bus.busy), 64'd0);
                check("rand idle start", 64'(bus.start), 64'd0);
                continue;
            end
            w    = rr_winner(pend, mlast);
            keep = ($urandom_range(0, 3) == 0);
            run_segment($sformatf("rand%0d", s), pend, $urandom_range(1, 6),
                        1'($urandom_range(0, 1)), keep, w);
            mlast = w;
            if (!keep) pend[w] = 1'b0;
        end
        bus.req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
